memory_cycle_sequencer: RTL and testbench

//  Sequences one memory read or write cycle through the buffer registers
//  (buffer_register_12 / buffer_register_3): clear, sense strobe, transfer strobes, regeneration.

---
 rtl/memory_cycle_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_memory_cycle_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// memory_cycle_sequencer
//
// Purpose:
//   Runs one memory read or write cycle through the buffer registers
//   (buffer_register_12 / buffer_register_3).
//   A read cycle goes CLEAR -> SENSE -> XFER -> REGEN -> DONE.
//   A write cycle skips SENSE.
//   The single buffer-register path is shared between two requesters, the
//   CPU and the PIO. When both ask in the same cycle, they are served
//   round-robin.
//
// Parameters:
//   CLR_CYC    cycles spent in CLEAR (cbrn held low), 1..15
//   SENSE_DLY  wait cycles in SENSE before the sense strobe, 1..15
//   REGEN_CYC  cycles spent in REGEN (module select held), 1..15
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   cpureq   CPU request, held until cpuack
//   cpuwr    CPU cycle type (1 = write), sampled at grant
//   cpumod   CPU memory module number, sampled at grant
//   pioreq   PIO request, held until pioack
//   piowr    PIO cycle type (1 = write), sampled at grant
//   piomod   PIO memory module number, sampled at grant
//   cpuack   one-cycle grant pulse to the CPU
//   pioack   one-cycle grant pulse to the PIO
//   cbrn     clear buffer register, active low
//   sbrx     sense strobe, buffer_register_3 path
//   sbry     sense strobe, syllable 1
//   sbrz     sense strobe, syllable 2
//   tr       transfer strobes TR1..TR14 (bit 0 = TR1)
//   msel     one-hot memory module select
//   busy     high whenever the sequencer is not idle
//   done     one-cycle completion pulse
//   owner    current or most recent owner (0 = CPU, 1 = PIO)
// ---------------------------------------------------------------------------
module memory_cycle_sequencer #(
    parameter int CLR_CYC   = 2,
    parameter int SENSE_DLY = 3,
    parameter int REGEN_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpureq,
    input  logic        cpuwr,
    input  logic [2:0]  cpumod,
    input  logic        pioreq,
    input  logic        piowr,
    input  logic [2:0]  piomod,
    output logic        cpuack,
    output logic        pioack,
    output logic        cbrn,
    output logic        sbrx,
    output logic        sbry,
    output logic        sbrz,
    output logic [13:0] tr,
    output logic [7:0]  msel,
    output logic        busy,
    output logic        done,
    output logic        owner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SENSE,
        S_XFER,
        S_REGEN,
        S_DONE
    } state_t;

    // The phase counter is loaded with (length - 1) on state entry.
    // The state ends in the cycle where the counter reads zero.
    localparam logic [3:0] CLR_LOAD   = 4'(CLR_CYC - 1);
    localparam logic [3:0] SENSE_LOAD = 4'(SENSE_DLY);
    localparam logic [3:0] REGEN_LOAD = 4'(REGEN_CYC - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        wr_q, wr_n;
    logic [2:0]  mod_q, mod_n;
    logic        owner_n;
    logic        last_served, last_n;
    logic        grant_cpu, grant_pio;

    logic        cpuack_n, pioack_n, cbrn_n, sbr_n, busy_n, done_n;
    logic [13:0] tr_n;
    logic [7:0]  msel_n;

    // Next-state logic.
    // Arbitration happens only in IDLE. When both requesters ask, the
    // grant goes to the one that was not served last, so a requester that
    // holds its request high alternates with the other one.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        wr_n      = wr_q;
        mod_n     = mod_q;
        owner_n   = owner;
        last_n    = last_served;
        grant_cpu = 1'b0;
        grant_pio = 1'b0;

        case (state)
            S_IDLE: begin
                if (cpureq && (!pioreq || last_served)) begin
                    grant_cpu = 1'b1;
                end else if (pioreq) begin
                    grant_pio = 1'b1;
                end
                if (grant_cpu || grant_pio) begin
                    state_n = S_CLEAR;
                    cnt_n   = CLR_LOAD;
                    wr_n    = grant_cpu ? cpuwr  : piowr;
                    mod_n   = grant_cpu ? cpumod : piomod;
                    owner_n = grant_pio;
                    last_n  = grant_pio;
                end
            end
            S_CLEAR: begin
                if (cnt == 4'd0) begin
                    if (wr_q) begin
                        state_n = S_XFER;
                        cnt_n   = 4'd0;
                    end else begin
                        state_n = S_SENSE;
                        cnt_n   = SENSE_LOAD;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_SENSE: begin
                if (cnt == 4'd0) begin
                    state_n = S_XFER;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_XFER: begin
                state_n = S_REGEN;
                cnt_n   = REGEN_LOAD;
            end
            S_REGEN: begin
                if (cnt == 4'd0) begin
                    state_n = S_DONE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = 4'd0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state.
    // Registering these values keeps every output glitch-free and aligned
    // with the state it describes.
    always_comb begin
        cpuack_n = grant_cpu;
        pioack_n = grant_pio;
        cbrn_n   = (state_n != S_CLEAR);
        sbr_n    = (state_n == S_SENSE) && (cnt_n == 4'd0);
        tr_n     = (state_n == S_XFER) ? 14'h3FFF : 14'h0000;
        busy_n   = (state_n != S_IDLE);
        done_n   = (state_n == S_DONE);
        msel_n   = 8'h00;
        if ((state_n == S_CLEAR) || (state_n == S_SENSE) ||
            (state_n == S_XFER)  || (state_n == S_REGEN)) begin
            msel_n = 8'h01 << mod_n;
        end
    end

    // State, latched request fields and the registered outputs.
    // Reset leaves last_served at PIO, so the first contest after reset
    // is won by the CPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            wr_q        <= 1'b0;
            mod_q       <= 3'd0;
            owner       <= 1'b0;
            last_served <= 1'b1;
            cpuack      <= 1'b0;
            pioack      <= 1'b0;
            cbrn        <= 1'b1;
            sbrx        <= 1'b0;
            sbry        <= 1'b0;
            sbrz        <= 1'b0;
            tr          <= 14'h0000;
            msel        <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            wr_q        <= wr_n;
            mod_q       <= mod_n;
            owner       <= owner_n;
            last_served <= last_n;
            cpuack      <= cpuack_n;
            pioack      <= pioack_n;
            cbrn        <= cbrn_n;
            sbrx        <= sbr_n;
            sbry        <= sbr_n;
            sbrz        <= sbr_n;
            tr          <= tr_n;
            msel        <= msel_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_memory_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_memory_cycle_sequencer
//
// Directed bench for memory_cycle_sequencer. It uses two instances:
//   dut  - default timing (CLR_CYC=2, SENSE_DLY=3, REGEN_CYC=4)
//   dut2 - minimum timing (all parameters 1)
// Cycle numbering: cycle 0 is the IDLE cycle in which the request is first
// visible. Outputs are sampled on the falling edge of each cycle.
// ---------------------------------------------------------------------------
module tb_memory_cycle_sequencer;

    logic        clk;
    logic        rst;
    logic        cpureq, cpuwr, pioreq, piowr;
    logic [2:0]  cpumod, piomod;
    logic        cpuack, pioack, cbrn, sbrx, sbry, sbrz, busy, done, owner;
    logic [13:0] tr;
    logic [7:0]  msel;

    logic        cpureq2, cpuwr2;
    logic [2:0]  cpumod2;
    logic        cpuack2, pioack2, cbrn2, sbrx2, sbry2, sbrz2, busy2, done2, owner2;
    logic [13:0] tr2;
    logic [7:0]  msel2;

    int tests;
    int fails;

    memory_cycle_sequencer dut (
        .clk(clk), .rst(rst),
        .cpureq(cpureq), .cpuwr(cpuwr), .cpumod(cpumod),
        .pioreq(pioreq), .piowr(piowr), .piomod(piomod),
        .cpuack(cpuack), .pioack(pioack), .cbrn(cbrn),
        .sbrx(sbrx), .sbry(sbry), .sbrz(sbrz),
        .tr(tr), .msel(msel), .busy(busy), .done(done), .owner(owner)
    );

    memory_cycle_sequencer #(.CLR_CYC(1), .SENSE_DLY(1), .REGEN_CYC(1)) dut2 (
        .clk(clk), .rst(rst),
        .cpureq(cpureq2), .cpuwr(cpuwr2), .cpumod(cpumod2),
        .pioreq(1'b0), .piowr(1'b0), .piomod(3'd0),
        .cpuack(cpuack2), .pioack(pioack2), .cbrn(cbrn2),
        .sbrx(sbrx2), .sbry(sbry2), .sbrz(sbrz2),
        .tr(tr2), .msel(msel2), .busy(busy2), .done(done2), .owner(owner2)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls far beyond the expected run length.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Hold reset for two edges, then check every output against its reset value.
    task automatic test_reset();
        rst = 1'b1;
        cpureq = 1'b0; cpuwr = 1'b0; cpumod = 3'd0;
        pioreq = 1'b0; piowr = 1'b0; piomod = 3'd0;
        cpureq2 = 1'b0; cpuwr2 = 1'b0; cpumod2 = 3'd0;
        repeat (2) @(negedge clk);
        tests++;
        if ({cpuack, pioack, cbrn, sbrx, sbry, sbrz, busy, done, owner} !== 9'b001000000) begin
            fails++;
            $display("[TB] FAIL reset ctrl: got %b want 001000000",
                     {cpuack, pioack, cbrn, sbrx, sbry, sbrz, busy, done, owner});
        end
        tests++;
        if (tr !== 14'h0 || msel !== 8'h0) begin
            fails++;
            $display("[TB] FAIL reset tr/msel: got tr=%h msel=%h want 0/0", tr, msel);
        end
        tests++;
        if (cbrn2 !== 1'b1 || busy2 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset dut2: got cbrn=%b busy=%b want 1/0", cbrn2, busy2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // CPU read of module 5. The request fields change after the grant to
    // show that they have no effect once the cycle is running.
    task automatic test_cpu_read();
        logic [7:0]  expCtrl, obsCtrl;
        logic [13:0] expTr;
        logic [7:0]  expMsel;
        cpureq = 1'b1; cpuwr = 1'b0; cpumod = 3'd5;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            obsCtrl = {cpuack, pioack, cbrn, sbrx, sbry, sbrz, busy, done};
            expCtrl = {c == 1, 1'b0, !(c <= 2), c == 6, c == 6, c == 6, c <= 12, c == 12};
            expTr   = (c == 7) ? 14'h3FFF : 14'h0;
            expMsel = (c <= 11) ? 8'h20 : 8'h00;
            tests++;
            if (obsCtrl !== expCtrl) begin
                fails++;
                $display("[TB] FAIL cpu_read ctrl cyc %0d: got %b want %b", c, obsCtrl, expCtrl);
            end
            tests++;
            if (tr !== expTr || msel !== expMsel) begin
                fails++;
                $display("[TB] FAIL cpu_read tr/msel cyc %0d: got %h/%h want %h/%h",
                         c, tr, msel, expTr, expMsel);
            end
            if (c == 1) begin
                tests++;
                if (owner !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL cpu_read owner: got %b want 0", owner);
                end
                cpureq = 1'b0; cpuwr = 1'b1; cpumod = 3'd2;
            end
        end
    endtask

    // PIO write to module 0: no sense strobes, and the transfer follows the clear phase directly.
    task automatic test_pio_write();
        logic [7:0]  expCtrl, obsCtrl;
        logic [13:0] expTr;
        logic [7:0]  expMsel;
        pioreq = 1'b1; piowr = 1'b1; piomod = 3'd0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            obsCtrl = {cpuack, pioack, cbrn, sbrx, sbry, sbrz, busy, done};
            expCtrl = {1'b0, c == 1, !(c <= 2), 1'b0, 1'b0, 1'b0, c <= 8, c == 8};
            expTr   = (c == 3) ? 14'h3FFF : 14'h0;
            expMsel = (c <= 7) ? 8'h01 : 8'h00;
            tests++;
            if (obsCtrl !== expCtrl) begin
                fails++;
                $display("[TB] FAIL pio_write ctrl cyc %0d: got %b want %b", c, obsCtrl, expCtrl);
            end
            tests++;
            if (tr !== expTr || msel !== expMsel) begin
                fails++;
                $display("[TB] FAIL pio_write tr/msel cyc %0d: got %h/%h want %h/%h",
                         c, tr, msel, expTr, expMsel);
            end
            if (c == 1) begin
                tests++;
                if (owner !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL pio_write owner: got %b want 1", owner);
                end
                pioreq = 1'b0;
            end
        end
    endtask

    // Both requesters hold their requests from reset. Each write cycle
    // lasts 8 cycles. Expected grants: CPU at 1, PIO at 10, CPU at 19.
    // Expected DONE pulses at 8 and 17.
    task automatic test_round_robin();
        int waited;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cpureq = 1'b1; cpuwr = 1'b1; cpumod = 3'd1;
        pioreq = 1'b1; piowr = 1'b1; piomod = 3'd6;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            tests++;
            if (cpuack !== (c == 1 || c == 19)) begin
                fails++;
                $display("[TB] FAIL round_robin cpuack cyc %0d: got %b", c, cpuack);
            end
            tests++;
            if (pioack !== (c == 10)) begin
                fails++;
                $display("[TB] FAIL round_robin pioack cyc %0d: got %b", c, pioack);
            end
            tests++;
            if (done !== (c == 8 || c == 17)) begin
                fails++;
                $display("[TB] FAIL round_robin done cyc %0d: got %b", c, done);
            end
            if (c == 11) begin
                tests++;
                if (owner !== 1'b1 || msel !== 8'h40) begin
                    fails++;
                    $display("[TB] FAIL round_robin pio owner/msel: got %b/%h want 1/40", owner, msel);
                end
            end
        end
        cpureq = 1'b0;
        pioreq = 1'b0;
        waited = 0;
        while (busy !== 1'b0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL round_robin drain: got busy=%b want 0", busy);
        end
    endtask

    // Reset is asserted in cycle 7 of a CPU read. All outputs must be back at their
    // reset values in cycle 8, and no DONE pulse may follow.
    task automatic test_reset_abort();
        cpureq = 1'b1; cpuwr = 1'b0; cpumod = 3'd3;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) cpureq = 1'b0;
            if (c == 7) begin
                tests++;
                if (tr !== 14'h3FFF) begin
                    fails++;
                    $display("[TB] FAIL abort pre-reset tr: got %h want 3fff", tr);
                end
                rst = 1'b1;
            end
            if (c == 8) begin
                tests++;
                if ({cbrn, busy, done} !== 3'b100 || msel !== 8'h0 || tr !== 14'h0) begin
                    fails++;
                    $display("[TB] FAIL abort cyc 8: got cbrn=%b busy=%b done=%b msel=%h tr=%h want 1/0/0/00/0000",
                             cbrn, busy, done, msel, tr);
                end
                rst = 1'b0;
            end
            if (c >= 9) begin
                tests++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL abort cyc %0d: got done=%b busy=%b want 0/0", c, done, busy);
                end
            end
        end
    endtask

    // A CPU request that rises in cycle 3 of a PIO write and falls in cycle 4 must
    // never be granted.
    task automatic test_dropped_req();
        pioreq = 1'b1; piowr = 1'b1; piomod = 3'd2;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) pioreq = 1'b0;
            if (c == 3) begin
                cpureq = 1'b1; cpuwr = 1'b0; cpumod = 3'd7;
            end
            if (c == 4) cpureq = 1'b0;
            tests++;
            if (cpuack !== 1'b0 || pioack !== (c == 1)) begin
                fails++;
                $display("[TB] FAIL dropped_req acks cyc %0d: got cpu=%b pio=%b", c, cpuack, pioack);
            end
            tests++;
            if (busy !== (c <= 8) || done !== (c == 8)) begin
                fails++;
                $display("[TB] FAIL dropped_req busy/done cyc %0d: got %b/%b", c, busy, done);
            end
        end
    endtask

    // Minimum-timing instance, read of module 3.
    // Expected: CLEAR in cycle 1, sense strobes in cycle 3, TR in cycle 4,
    // DONE in cycle 6.
    task automatic test_min_params();
        logic [8:0]  expCtrl, obsCtrl;
        logic [13:0] expTr;
        logic [7:0]  expMsel;
        cpureq2 = 1'b1; cpuwr2 = 1'b0; cpumod2 = 3'd3;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) cpureq2 = 1'b0;
            obsCtrl = {cpuack2, pioack2, cbrn2, sbrx2, sbry2, sbrz2, busy2, done2, owner2};
            expCtrl = {c == 1, 1'b0, c != 1, c == 3, c == 3, c == 3, c <= 6, c == 6, 1'b0};
            expTr   = (c == 4) ? 14'h3FFF : 14'h0;
            expMsel = (c <= 5) ? 8'h08 : 8'h00;
            tests++;
            if (obsCtrl !== expCtrl) begin
                fails++;
                $display("[TB] FAIL min_params ctrl cyc %0d: got %b want %b", c, obsCtrl, expCtrl);
            end
            tests++;
            if (tr2 !== expTr || msel2 !== expMsel) begin
                fails++;
                $display("[TB] FAIL min_params tr/msel cyc %0d: got %h/%h want %h/%h",
                         c, tr2, msel2, expTr, expMsel);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_cpu_read();
        test_pio_write();
        test_round_robin();
        test_reset_abort();
        test_dropped_req();
        test_min_params();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
